// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of a single-ported synchronous SRAM macro.
// Port A is a Wishbone slave window at 0x8000..0xBFFF; port B is a word-addressed requester.
module sram_port_arbiter #(
  parameter int AW = 10
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_dat_i,
  input  logic [31:0]   wbs_adr_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [3:0]    b_sel,
  input  logic [AW-1:0] b_adr,
  input  logic [31:0]   b_wdata,
  output logic          b_gnt,
  output logic          b_done,
  output logic [31:0]   b_rdata,
  output logic [AW-1:0] AD,
  output logic [31:0]   DI,
  output logic [31:0]   BEN,
  output logic          EN,
  output logic          R_WB,
  output logic          CLKin,
  input  logic [31:0]   DO,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          last_b_q, last_b_d;
  logic          win_b_q, win_b_d;
  logic          aborted_q, aborted_d;
  logic          en_q, en_d;
  logic          rwb_q, rwb_d;
  logic [AW-1:0] ad_q, ad_d;
  logic [31:0]   di_q, di_d;
  logic [31:0]   ben_q, ben_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          a_req;
  logic          grant_a;
  logic          grant_b;
  logic [31:0]   a_ben;
  logic [31:0]   b_ben;
  logic          unused_adr_bits;

  assign a_req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[15:14] == 2'b10);

  // On a tie the port that did not win last time gets the SRAM.
  assign grant_a = a_req & (~b_req | last_b_q);
  assign grant_b = b_req & (~a_req | ~last_b_q);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ben
      assign a_ben[8*gi +: 8] = {8{wbs_sel_i[gi]}};
      assign b_ben[8*gi +: 8] = {8{b_sel[gi]}};
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    last_b_d  = last_b_q;
    win_b_d   = win_b_q;
    aborted_d = aborted_q;
    en_d      = 1'b0;
    rwb_d     = rwb_q;
    ad_d      = ad_q;
    di_d      = di_q;
    ben_d     = ben_q;
    rdata_d   = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (grant_a) begin
          state_d   = S_ACCESS;
          en_d      = 1'b1;
          last_b_d  = 1'b0;
          win_b_d   = 1'b0;
          aborted_d = 1'b0;
          ad_d      = wbs_adr_i[AW+1:2];
          di_d      = wbs_dat_i;
          rwb_d     = ~wbs_we_i;
          ben_d     = wbs_we_i ? a_ben : 32'hFFFF_FFFF;
        end else if (grant_b) begin
          state_d   = S_ACCESS;
          en_d      = 1'b1;
          last_b_d  = 1'b1;
          win_b_d   = 1'b1;
          aborted_d = 1'b0;
          ad_d      = b_adr;
          di_d      = b_wdata;
          rwb_d     = ~b_we;
          ben_d     = b_we ? b_ben : 32'hFFFF_FFFF;
        end
      end
      S_ACCESS: begin
        state_d = S_CAPTURE;
        if (!win_b_q && !wbs_cyc_i) begin
          aborted_d = 1'b1;
        end
      end
      S_CAPTURE: begin
        state_d = S_ACK;
        if (!win_b_q && !wbs_cyc_i) begin
          aborted_d = 1'b1;
        end
        if (rwb_q) begin
          rdata_d = DO;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      last_b_q  <= 1'b1;
      win_b_q   <= 1'b0;
      aborted_q <= 1'b0;
      en_q      <= 1'b0;
      rwb_q     <= 1'b1;
      ad_q      <= '0;
      di_q      <= '0;
      ben_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      win_b_q   <= win_b_d;
      aborted_q <= aborted_d;
      en_q      <= en_d;
      rwb_q     <= rwb_d;
      ad_q      <= ad_d;
      di_q      <= di_d;
      ben_q     <= ben_d;
      rdata_q   <= rdata_d;
    end
  end

  // A Wishbone master that has walked away never sees a stray acknowledge.
  assign wbs_ack_o = (state_q == S_ACK) & ~win_b_q & ~aborted_q & wbs_cyc_i & ~wb_rst_i;
  assign b_done    = (state_q == S_ACK) & win_b_q & ~wb_rst_i;
  assign b_gnt     = (state_q == S_IDLE) & grant_b & ~wb_rst_i;
  assign busy      = (state_q != S_IDLE);

  assign wbs_dat_o = rdata_q;
  assign b_rdata   = rdata_q;

  assign AD    = ad_q;
  assign DI    = di_q;
  assign BEN   = ben_q;
  assign EN    = en_q;
  assign R_WB  = rwb_q;
  assign CLKin = wb_clk_i;

  assign unused_adr_bits = ^wbs_adr_i;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter: a behavioural SRAM plus a transaction-level
// reference (memory image, round-robin memory, last read value) predicts every output.
module tb_sram_port_arbiter;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          wb_rst_i;
  logic          wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]    wbs_sel_i;
  logic [31:0]   wbs_dat_i, wbs_adr_i;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic          b_req, b_we;
  logic [3:0]    b_sel;
  logic [AW-1:0] b_adr;
  logic [31:0]   b_wdata;
  logic          b_gnt, b_done;
  logic [31:0]   b_rdata;
  logic [AW-1:0] AD;
  logic [31:0]   DI, BEN;
  logic          EN, R_WB, CLKin;
  logic [31:0]   DO;
  logic          busy;

  always #5 clk = ~clk;

  sram_port_arbiter #(.AW(AW)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .b_req(b_req), .b_we(b_we), .b_sel(b_sel), .b_adr(b_adr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .AD(AD), .DI(DI), .BEN(BEN), .EN(EN), .R_WB(R_WB), .CLKin(CLKin), .DO(DO),
    .busy(busy)
  );

  // Behavioural synchronous SRAM macro (environment, not the reference).
  logic [31:0] sram_mem [0:(1<<AW)-1];
  logic        sram_clear;
  always @(posedge CLKin) begin
    if (sram_clear) begin
      for (int i = 0; i < (1 << AW); i++) sram_mem[i] <= 32'h9E37_79B9 * i;
    end else if (EN) begin
      if (R_WB) DO <= sram_mem[AD];
      else      sram_mem[AD] <= (sram_mem[AD] & ~BEN) | (DI & BEN);
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:(1<<AW)-1];
  bit          prev_win_b;
  logic [31:0] last_rd;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_txn    = 0;

  // Values observed during the latest transaction, for the directed checks
  logic        obs_gnt_b;
  logic [31:0] obs_ben, obs_rd;
  logic [AW-1:0] obs_ad;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic idle_inputs();
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
    wbs_dat_i = 0; wbs_adr_i = 0;
    b_req = 0; b_we = 0; b_sel = 0; b_adr = 0; b_wdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    wb_rst_i = 1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    wb_rst_i = 0;
    prev_win_b = 1'b1;
    last_rd    = '0;
  endtask

  // One arbitration round, called at a negedge with the DUT idle; checks T..T+4.
  task automatic run_txn(input bit a_on, input logic [31:0] a_adr, input bit a_we,
                         input logic [3:0] a_sel, input logic [31:0] a_dat,
                         input bit b_on, input logic [AW-1:0] b_ad, input bit b_w,
                         input logic [3:0] b_s, input logic [31:0] b_d);
    bit a_ok, win_a, win_b, ex_we;
    logic [AW-1:0] ex_ad;
    logic [31:0] ex_ben, ex_di, ex_rd, wmask;
    string who;
    wbs_cyc_i = a_on; wbs_stb_i = a_on; wbs_we_i = a_we;
    wbs_sel_i = a_sel; wbs_dat_i = a_dat; wbs_adr_i = a_adr;
    b_req = b_on; b_we = b_w; b_sel = b_s; b_adr = b_ad; b_wdata = b_d;
    a_ok  = a_on && (a_adr[15:14] == 2'b10);
    win_a = (a_ok && b_on) ? prev_win_b : a_ok;
    win_b = b_on && !win_a;
    #1;
    obs_gnt_b = b_gnt;
    check_eq("b_gnt_T", b_gnt, win_b);
    check_eq("busy_T", busy, 0);
    @(negedge clk);
    b_req = 0; b_we = $urandom; b_sel = $urandom; b_adr = $urandom; b_wdata = $urandom;
    if (!win_a && !win_b) begin
      check_eq("en_nogrant", EN, 0);
      check_eq("busy_nogrant", busy, 0);
      check_eq("ack_nogrant", wbs_ack_o, 0);
      wbs_cyc_i = 0; wbs_stb_i = 0;
      $display("txn %0d: a_on=%0b adr=%h b_on=%0b -> no grant", n_txn, a_on, a_adr, b_on);
      n_txn++;
      return;
    end
    ex_ad  = win_a ? a_adr[AW+1:2] : b_ad;
    ex_we  = win_a ? a_we : b_w;
    ex_di  = win_a ? a_dat : b_d;
    ex_ben = ex_we ? byte_mask(win_a ? a_sel : b_s) : 32'hFFFF_FFFF;
    obs_ben = BEN;
    obs_ad  = AD;
    check_eq("en_T1", EN, 1);
    check_eq("busy_T1", busy, 1);
    check_eq("b_gnt_T1", b_gnt, 0);
    check_eq("ad_T1", AD, ex_ad);
    check_eq("rwb_T1", R_WB, !ex_we);
    check_eq("ben_T1", BEN, ex_ben);
    if (ex_we) check_eq("di_T1", DI, ex_di);
    ex_rd = ref_mem[ex_ad];
    if (ex_we) begin
      wmask = byte_mask(win_a ? a_sel : b_s);
      ref_mem[ex_ad] = (ref_mem[ex_ad] & ~wmask) | (ex_di & wmask);
    end
    prev_win_b = win_b;
    @(negedge clk);
    check_eq("en_T2", EN, 0);
    check_eq("ack_T2", wbs_ack_o, 0);
    check_eq("done_T2", b_done, 0);
    @(negedge clk);
    if (!ex_we) last_rd = ex_rd;
    obs_rd = win_a ? wbs_dat_o : b_rdata;
    check_eq("ack_T3", wbs_ack_o, win_a);
    check_eq("done_T3", b_done, win_b);
    check_eq("adat_T3", wbs_dat_o, last_rd);
    check_eq("brdata_T3", b_rdata, last_rd);
    wbs_cyc_i = 0; wbs_stb_i = 0;
    @(negedge clk);
    check_eq("busy_T4", busy, 0);
    check_eq("ack_T4", wbs_ack_o, 0);
    check_eq("done_T4", b_done, 0);
    check_eq("adat_T4", wbs_dat_o, last_rd);
    who = win_a ? "A" : "B";
    $display("txn %0d: winner=%s we=%0b ad=%0d ben=%h data=%h", n_txn, who, ex_we, ex_ad,
             ex_ben, ex_we ? ex_di : ex_rd);
    n_txn++;
  endtask

  initial begin
    logic [31:0] ra;
    wb_rst_i   = 1;
    sram_clear = 1;
    idle_inputs();
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 32'h9E37_79B9 * i;
    @(negedge clk);
    @(negedge clk);
    sram_clear = 0;

    // Reset state
    check_eq("rst_busy", busy, 0);
    check_eq("rst_en", EN, 0);
    check_eq("rst_rwb", R_WB, 1);
    check_eq("rst_ad", AD, 0);
    check_eq("rst_di", DI, 0);
    check_eq("rst_ben", BEN, 0);
    check_eq("rst_ack", wbs_ack_o, 0);
    check_eq("rst_done", b_done, 0);
    check_eq("rst_rdata", wbs_dat_o, 0);
    wb_rst_i = 0;
    prev_win_b = 1'b1;
    last_rd = '0;

    // Tie arbitration after reset: A, B, A
    run_txn(1, 32'h0000_8020, 1, 4'hF, 32'h0101_0101, 1, 10'd9, 1, 4'hF, 32'h0202_0202);
    check_eq("rr_first_a", obs_gnt_b, 0);
    run_txn(1, 32'h0000_8024, 0, 4'hF, 32'h0, 1, 10'd8, 0, 4'hF, 32'h0);
    check_eq("rr_second_b", obs_gnt_b, 1);
    run_txn(1, 32'h0000_8028, 0, 4'hF, 32'h0, 1, 10'd9, 0, 4'hF, 32'h0);
    check_eq("rr_third_a", obs_gnt_b, 0);

    // A write then read of 0x8010
    run_txn(1, 32'h0000_8010, 1, 4'hF, 32'hDEAD_BEEF, 0, '0, 0, 4'h0, 32'h0);
    check_eq("a_wr_ad", obs_ad, 4);
    run_txn(1, 32'h0000_8010, 0, 4'h0, 32'h0, 0, '0, 0, 4'h0, 32'h0);
    check_eq("a_rd_data", obs_rd, 32'hDEAD_BEEF);

    // B byte-lane write
    run_txn(0, 32'h0, 0, 4'h0, 32'h0, 1, 10'd5, 1, 4'hF, 32'h1122_3344);
    run_txn(0, 32'h0, 0, 4'h0, 32'h0, 1, 10'd5, 1, 4'b0010, 32'h0000_AB00);
    check_eq("b_wr_ben", obs_ben, 32'h0000_FF00);
    run_txn(0, 32'h0, 0, 4'h0, 32'h0, 1, 10'd5, 0, 4'h0, 32'h0);
    check_eq("b_rd_data", obs_rd, 32'h1122_AB44);

    // Out-of-window A: alone, then alongside B
    run_txn(1, 32'h0000_4000, 1, 4'hF, 32'h5555_5555, 0, '0, 0, 4'h0, 32'h0);
    run_txn(1, 32'h0000_4000, 0, 4'hF, 32'h0, 1, 10'd5, 0, 4'h0, 32'h0);
    check_eq("oow_b_served", obs_rd, 32'h1122_AB44);

    // A abort: cyc dropped during ACCESS, the write still lands
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
    wbs_adr_i = 32'h0000_801C; wbs_dat_i = 32'hCAFE_F00D;
    @(negedge clk);
    check_eq("abort_en", EN, 1);
    wbs_cyc_i = 0; wbs_stb_i = 0;
    ref_mem[7] = 32'hCAFE_F00D;
    prev_win_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("abort_noack", wbs_ack_o, 0);
    @(negedge clk);
    check_eq("abort_busy_T4", busy, 0);
    $display("txn %0d: A write 0x801C aborted", n_txn);
    n_txn++;
    run_txn(1, 32'h0000_801C, 0, 4'h0, 32'h0, 0, '0, 0, 4'h0, 32'h0);
    check_eq("abort_wr_landed", obs_rd, 32'hCAFE_F00D);

    // Reset during CAPTURE of a B write
    b_req = 1; b_we = 1; b_sel = 4'hF; b_adr = 10'd12; b_wdata = 32'h7777_1234;
    @(negedge clk);
    b_req = 0;
    ref_mem[12] = 32'h7777_1234;
    @(negedge clk);
    wb_rst_i = 1;
    @(negedge clk);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_en", EN, 0);
    check_eq("midrst_rwb", R_WB, 1);
    check_eq("midrst_ad", AD, 0);
    check_eq("midrst_di", DI, 0);
    check_eq("midrst_ben", BEN, 0);
    check_eq("midrst_done", b_done, 0);
    check_eq("midrst_ack", wbs_ack_o, 0);
    check_eq("midrst_rdata", b_rdata, 0);
    wb_rst_i = 0;
    prev_win_b = 1'b1;
    last_rd = '0;
    @(negedge clk);
    check_eq("midrst_done_after", b_done, 0);
    $display("txn %0d: B write aborted by reset", n_txn);
    n_txn++;

    // Randomized mix over a small address range so reads hit earlier writes
    for (int k = 0; k < 60; k++) begin
      ra = $urandom;
      ra[15:14] = ($urandom_range(0, 3) != 0) ? 2'b10 : 2'(ra[15:14] ^ 2'b10);
      ra[AW+1:2] = AW'($urandom_range(0, 15));
      run_txn(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), 4'($urandom),
              $urandom, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 4'($urandom), $urandom);
    end

    // Final rounds after a plain reset: tie must go to A again
    do_reset();
    run_txn(1, 32'h0000_8004, 0, 4'h0, 32'h0, 1, 10'd3, 0, 4'h0, 32'h0);
    check_eq("rr_after_reset", obs_gnt_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter: AW, default 10, SRAM word-address width.
REQ-002 Port: wb_clk_i  in  1  sole clock; also forwarded to the SRAM clock.
REQ-003 Port: wb_rst_i  in  1  reset, synchronous, active-high.
REQ-004 Ports: wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone slave controls (port A).
REQ-005 Ports: wbs_sel_i  in  4, wbs_dat_i  in  32, wbs_adr_i  in  32  Wishbone byte-select, write data, byte address.
REQ-006 Ports: wbs_ack_o  out  1, wbs_dat_o  out  32  Wishbone acknowledge and read data.
REQ-007 Ports: b_req  in  1, b_we  in  1, b_sel  in  4, b_adr  in  AW, b_wdata  in  32  port B word-addressed requester.
REQ-008 Ports: b_gnt  out  1, b_done  out  1, b_rdata  out  32  port B grant pulse, completion pulse, read data.
REQ-009 SRAM ports: AD out AW, DI out 32, BEN out 32, EN out 1, R_WB out 1 (1=read, 0=write), CLKin out 1, DO in 32.
REQ-010 Port: busy  out  1  high whenever FSM is not IDLE.

Function
REQ-011 Port A request = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[15:14]==2'b10); port A word address = wbs_adr_i[AW+1:2].
REQ-012 Port B request = b_req.
REQ-013 FSM states: IDLE, ACCESS, CAPTURE, ACK; ACCESS->CAPTURE->ACK->IDLE unconditionally.
REQ-014 IDLE with at least one request: grant per REQ-015, register AD/DI/BEN/R_WB from winner, set EN=1, go to ACCESS; with no request, stay IDLE.
REQ-015 Arbitration: single requester wins; both requesting -> winner is the port not granted last (round robin); last-grant register resets to B, so A wins the first tie.
REQ-016 b_gnt is a one-cycle pulse in the IDLE cycle in which B wins; B fields are sampled in that cycle and B may change them afterwards.
REQ-017 EN=1 only during ACCESS; EN=0 in all other states; AD/DI/BEN/R_WB hold their value outside ACCESS.
REQ-018 BEN[8i+7:8i] = {8{sel[i]}} of winning port, i=0..3; reads drive BEN=32'hFFFF_FFFF.
REQ-019 CAPTURE: DO registered into read-data register (reads only; unchanged on writes).
REQ-020 ACK, winner A: wbs_ack_o=1 for exactly that one cycle, wbs_dat_o = read-data register; wbs_ack_o=0 in every other state.
REQ-021 ACK, winner B: b_done=1 for exactly one cycle, b_rdata = read-data register (valid only for reads).
REQ-022 wbs_dat_o and b_rdata hold the last captured read data outside ACK.
REQ-023 Latency: request seen in IDLE at cycle T -> EN at T+1 -> ack/done at T+3 -> IDLE, next grant possible at T+4.
REQ-024 Port A abort: if wbs_cyc_i drops after grant, SRAM access completes, wbs_ack_o is suppressed in ACK, FSM returns to IDLE.
REQ-025 Port A requests outside 0x8000..0xBFFF are never granted and never acked.
REQ-026 CLKin = wb_clk_i (combinational pass-through).

Reset
REQ-027 While wb_rst_i=1 at a clock edge: FSM->IDLE, EN=0, R_WB=1, AD=0, DI=0, BEN=0, wbs_ack_o=0, b_gnt=0, b_done=0, read-data register=0, last-grant=B, busy=0.
REQ-028 Reset mid-transaction aborts it: no ack/done is issued for the aborted access.

Verification
REQ-029 A write 0x8010, data 0xDEADBEEF, sel 4'hF, then read 0x8010 -> EN at T+1 with AD=4, ack at T+3, read returns 0xDEADBEEF.
REQ-030 B write b_adr=5, sel 4'b0010, data 0x0000AB00 over 0x11223344 -> B read of 5 returns 0x1122AB44; BEN=32'h0000FF00 during the write.
REQ-031 A and B request together in 3 consecutive arbitrations -> grants A, B, A; neither port starves.
REQ-032 A access to 0x4000 -> no EN, no ack, FSM stays IDLE; concurrent B request is still served.
REQ-033 wbs_cyc_i dropped in ACCESS -> EN pulse occurs, no wbs_ack_o, busy low at T+4.
REQ-034 wb_rst_i asserted in CAPTURE -> next cycle IDLE, all outputs at REQ-027 values, no ack/done.
